// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single shared memory port.
// Data requests normally win. A fetch request that keeps losing is guaranteed
// service after STARVE_LIMIT consecutive data grants.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    // fetch port
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    // data port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    // shared memory port
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic              data_sel;
    logic              fetch_sel;

    // Port selection and grants. Data is only held back when a fetch is actually
    // waiting and has been passed over STARVE_LIMIT times; with no fetch pending
    // the data port must still be served, otherwise a saturated counter left over
    // from a withdrawn fetch request would lock the data port out. Grants are
    // gated by rst_n so nothing is accepted while reset is asserted.
    always_comb begin
        data_sel  = d_req && ((starve_cnt_q < LIMIT) || !if_req);
        fetch_sel = if_req && !data_sel;
        d_gnt     = rst_n && (state_q == IDLE) && data_sel;
        if_gnt    = rst_n && (state_q == IDLE) && fetch_sel;
    end

    // Next-state logic: capture the granted request, then wait for mem_ready.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_rvalid_d  = 1'b0;
        d_rvalid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_gnt) begin
                    state_d = BUSY_D;
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    be_d    = d_be;
                    if (if_req) begin
                        starve_cnt_d = (starve_cnt_q == LIMIT) ? LIMIT
                                                               : starve_cnt_q + CNT_W'(1);
                    end else begin
                        starve_cnt_d = '0;
                    end
                end else if (if_gnt) begin
                    state_d      = BUSY_I;
                    addr_d       = if_addr;
                    we_d         = 1'b0;
                    wdata_d      = 32'h0;
                    be_d         = 4'hF;
                    starve_cnt_d = '0;
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    if_rdata_d  = mem_rdata;
                    if_rvalid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    if (!we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    d_rvalid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            addr_q       <= 32'h0;
            we_q         <= 1'b0;
            wdata_q      <= 32'h0;
            be_q         <= 4'h0;
            if_rdata_q   <= 32'h0;
            d_rdata_q    <= 32'h0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_rvalid_q  <= if_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
        end
    end

    // mem_req follows the state register directly, so it drops as soon as reset hits.
    assign mem_req   = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: maximum number of consecutive data-port grants made while a fetch request is pending.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-004 SHALL have port if_req, input, 1 bit: fetch request, held until if_gnt.
REQ-005 SHALL have port if_addr, input, 32 bits: fetch byte address.
REQ-006 SHALL have port if_gnt, output, 1 bit: fetch request accepted this cycle.
REQ-007 SHALL have port if_rvalid, output, 1 bit: fetch data valid, one-cycle pulse.
REQ-008 SHALL have port if_rdata, output, 32 bits: fetched instruction.
REQ-009 SHALL have port d_req, input, 1 bit: data request, held until d_gnt.
REQ-010 SHALL have port d_we, input, 1 bit: data write enable (1 = store, 0 = load).
REQ-011 SHALL have port d_addr, input, 32 bits: data byte address.
REQ-012 SHALL have port d_wdata, input, 32 bits: store data.
REQ-013 SHALL have port d_be, input, 4 bits: store byte enables.
REQ-014 SHALL have port d_gnt, output, 1 bit: data request accepted this cycle.
REQ-015 SHALL have port d_rvalid, output, 1 bit: data access complete, one-cycle pulse, for loads and stores.
REQ-016 SHALL have port d_rdata, output, 32 bits: load data.
REQ-017 SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, 32), mem_wdata (output, 32), mem_be (output, 4), mem_ready (input, 1) and mem_rdata (input, 32), forming the single shared memory port.

Function
REQ-018 SHALL implement the states IDLE, BUSY_I and BUSY_D.
REQ-019 In IDLE, SHALL select the data port if d_req=1 and starve_cnt<STARVE_LIMIT; otherwise SHALL select fetch if if_req=1.
- Consequence: data wins unless if_req=1 and starve_cnt=STARVE_LIMIT, in which case fetch wins.
REQ-020 SHALL make if_gnt/d_gnt combinational, asserted only in IDLE and only for the selected port; at most one grant per cycle.
REQ-021 On a grant, SHALL capture address, we, wdata and be into registers.
- A fetch grant SHALL capture we=0 and be=4'hF.
- SHALL go to BUSY_I or BUSY_D at the next edge.
REQ-022 In BUSY_*, SHALL drive mem_req=1 and the mem_* fields from the captured registers, held stable until mem_ready=1.
REQ-023 On a BUSY_* cycle with mem_ready=1, SHALL:
- register mem_rdata into if_rdata (BUSY_I) or d_rdata (BUSY_D load);
- pulse the matching rvalid in the next cycle;
- return to IDLE at that edge.
REQ-024 Latency SHALL be as follows: grant in cycle N; mem_req from N+1; if mem_ready in cycle M≥N+1, rvalid in M+1, and a new grant is possible in M+1. Zero-wait throughput is one access per 2 cycles.
REQ-025 Store completion SHALL pulse d_rvalid and leave d_rdata unchanged.
REQ-026 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL:
- increment on a d_gnt while if_req=1, saturating at STARVE_LIMIT;
- clear on any if_gnt;
- clear on a d_gnt while if_req=0.
REQ-027 Outside BUSY_*, SHALL hold mem_req=0; mem_* fields may hold stale values.
REQ-028 A request deasserted before its grant SHALL be ignored; requests arriving during BUSY_* SHALL wait; mem_ready outside BUSY_* SHALL be ignored.
REQ-029 SHALL perform no address alignment checks; addresses pass through unmodified.

Reset
REQ-030 While rst_n=0, SHALL hold:
- state=IDLE and starve_cnt=0;
- if_gnt, d_gnt, if_rvalid, d_rvalid and mem_req at 0;
- if_rdata, d_rdata and the captured registers at 0.
REQ-031 Reset asserted mid-transaction SHALL abort it: mem_req drops asynchronously, and no rvalid is produced for the aborted access.
REQ-032 After rst_n deasserts, SHALL issue the first grant no earlier than the first rising edge with rst_n=1.

Verification
REQ-033 Single fetch: if_req with if_addr=0x100, mem_ready in the first BUSY cycle, mem_rdata=0x00500093 -> if_gnt in N, mem_req in N+1, if_rvalid=1 with if_rdata=0x00500093 in N+2.
REQ-034 Simultaneous requests: if_req and d_req both asserted, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=4'b0011 -> d_gnt first with mem_we=1 and mem_be=4'b0011, d_rvalid pulses, then if_gnt.
REQ-035 Starvation: if_req held, d_req held continuously, STARVE_LIMIT=3 -> exactly 3 d_gnt, then 1 if_gnt, then the pattern repeats.
REQ-036 Wait states: load with mem_ready delayed 4 cycles -> mem_req and mem_addr held stable 4 cycles, d_rvalid exactly once, one cycle after mem_ready.
REQ-037 Reset mid-access: rst_n=0 while in BUSY_D -> mem_req=0 immediately, no d_rvalid, and after release an if_req is granted at the first edge.
